// File: rtl/polyphase_sched.sv
// Phase scheduler for the polyphase IIR output path: one clock plus a frame strobe,
// descending branch select, warm-up/drain validity gating and frame-aligned bank switches.
module polyphase_sched #(
   parameter int PHASES = 3,
   parameter int WARMUP = 2
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       enable_i,
   input  logic       bank_req_i,
   input  logic       bank_next_i,
   output logic [1:0] phase_o,
   output logic       frame_stb_o,
   output logic       out_valid_o,
   output logic       busy_o,
   output logic       bank_ack_o,
   output logic       bank_act_o
);

   typedef enum logic [1:0] {IDLE, WARM, RUN, DRAIN} state_t;

   localparam logic [1:0] PH_MAX = 2'(PHASES - 1);
   localparam logic [3:0] WU     = 4'(WARMUP);

   state_t     state_q, state_d;
   logic [1:0] phase_q, phase_d;
   logic [3:0] wcnt_q, wcnt_d;
   logic       stb_q, stb_d;
   logic       valid_q, valid_d;
   logic       busy_q, busy_d;
   logic       act_q, act_d;
   logic       ack_q, ack_d;
   logic       pend_q, pend_d;
   logic       pnext_q, pnext_d;

   logic       ph_last;
   logic       req_pend;
   logic       req_val;
   logic       commit;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      ph_last = (phase_q == 2'd0);

      case (state_q)
         IDLE: begin
            if (enable_i) begin
               state_d = WARM;
               wcnt_d  = '0;
            end
         end
         WARM: begin
            if (ph_last) begin
               wcnt_d = wcnt_q + 4'd1;
               if (!enable_i)
                  state_d = IDLE;
               else if (wcnt_q + 4'd1 == WU)
                  state_d = RUN;
            end
         end
         RUN: begin
            // Stopping on the last phase skips DRAIN so no new frame is started.
            if (!enable_i)
               state_d = ph_last ? IDLE : DRAIN;
         end
         DRAIN: begin
            if (ph_last)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Every exit to IDLE happens on a phase-0 cycle, so wrap and hold coincide.
      phase_d = (state_q == IDLE || ph_last) ? PH_MAX : phase_q - 2'd1;
      stb_d   = (state_d != IDLE) && (phase_d == PH_MAX);
      valid_d = (state_d == RUN) || (state_d == DRAIN);
      busy_d  = (state_d != IDLE);

      // A seen request stays pending until a commit edge, even if bank_req drops.
      req_pend = bank_req_i | pend_q;
      req_val  = bank_req_i ? bank_next_i : pnext_q;
      commit   = req_pend && ((state_q == IDLE) || stb_d);
      pend_d   = req_pend && !commit;
      pnext_d  = req_val;
      act_d    = commit ? req_val : act_q;
      ack_d    = commit;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= IDLE;
         phase_q <= PH_MAX;
         wcnt_q  <= '0;
         stb_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         act_q   <= 1'b0;
         ack_q   <= 1'b0;
         pend_q  <= 1'b0;
         pnext_q <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         wcnt_q  <= wcnt_d;
         stb_q   <= stb_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         act_q   <= act_d;
         ack_q   <= ack_d;
         pend_q  <= pend_d;
         pnext_q <= pnext_d;
      end
   end

   assign phase_o     = phase_q;
   assign frame_stb_o = stb_q;
   assign out_valid_o = valid_q;
   assign busy_o      = busy_q;
   assign bank_ack_o  = ack_q;
   assign bank_act_o  = act_q;

endmodule

// File: tb/tb_polyphase_sched.sv
// Bench for polyphase_sched: frame-count reference model compared every cycle,
// plus directed vectors with literal expectations (defaults and PHASES=4/WARMUP=1).
module tb_polyphase_sched;

   localparam int P = 3;
   localparam int W = 2;

   logic       clk = 1'b0;
   logic       reset, en, req, nxt, en2;
   logic [1:0] phase, phase2;
   logic       stb, ov, busy, ack, act;
   logic       stb2, ov2, busy2, ack2, act2;

   always #5 clk = ~clk;

   polyphase_sched #(.PHASES(P), .WARMUP(W)) u_dut (
      .clk_i(clk), .reset_i(reset), .enable_i(en), .bank_req_i(req), .bank_next_i(nxt),
      .phase_o(phase), .frame_stb_o(stb), .out_valid_o(ov), .busy_o(busy),
      .bank_ack_o(ack), .bank_act_o(act));

   polyphase_sched #(.PHASES(4), .WARMUP(1)) u_dut4 (
      .clk_i(clk), .reset_i(reset), .enable_i(en2), .bank_req_i(1'b0), .bank_next_i(1'b0),
      .phase_o(phase2), .frame_stb_o(stb2), .out_valid_o(ov2), .busy_o(busy2),
      .bank_ack_o(ack2), .bank_act_o(act2));

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [7:0] a, input logic [7:0] e);
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, a, e, $time);
   endtask

   // Reference model: activity is a count of cycles since start; phase, strobe and
   // validity follow from that count, the bank from a pending flag.
   bit m_act, m_stop, m_pend, m_pval, m_bact, m_ack, armed;
   int m_n;

   always @(posedge clk) begin
      bit was_idle;
      if (!reset) begin
         m_act = 0; m_n = 0; m_stop = 0; m_pend = 0; m_pval = 0;
         m_bact = 0; m_ack = 0; armed = 1;
      end else begin
         was_idle = !m_act;
         if (req) begin m_pend = 1; m_pval = nxt; end
         if (m_act) begin
            if (m_n >= W * P && !en) m_stop = 1;
            if ((m_n % P == P - 1) && (m_stop || !en)) m_act = 0;
            else m_n++;
         end else if (en) begin
            m_act = 1; m_n = 0; m_stop = 0;
         end
         m_ack = 0;
         if (m_pend && (was_idle || (m_act && m_n % P == 0))) begin
            m_bact = m_pval; m_ack = 1; m_pend = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("m_phase", 8'(phase), 8'(m_act ? P - 1 - (m_n % P) : P - 1));
         chk("m_stb",   8'(stb),   8'(m_act && (m_n % P == 0)));
         chk("m_valid", 8'(ov),    8'(m_act && (m_n >= W * P)));
         chk("m_busy",  8'(busy),  8'(m_act));
         chk("m_ack",   8'(ack),   8'(m_ack));
         chk("m_bank",  8'(act),   8'(m_bact));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int ph_tab [8] = '{2, 1, 0, 2, 1, 0, 2, 1};
   int stb_tab[8] = '{1, 0, 0, 1, 0, 0, 1, 0};
   int ov_tab [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
   int ph4_tab[8] = '{3, 2, 1, 0, 3, 2, 1, 0};
   int ov4_tab[8] = '{0, 0, 0, 0, 1, 1, 1, 1};

   initial begin
      reset = 0; en = 0; req = 0; nxt = 0; en2 = 0;
      repeat (3) step();
      chk("rst_phase",  8'(phase),  8'd2);
      chk("rst_stb",    8'(stb),    8'd0);
      chk("rst_valid",  8'(ov),     8'd0);
      chk("rst_busy",   8'(busy),   8'd0);
      chk("rst_bank",   8'(act),    8'd0);
      chk("rst_ack",    8'(ack),    8'd0);
      chk("rst_phase4", 8'(phase2), 8'd3);

      reset = 1; step();
      en = 1; en2 = 1;
      for (int c = 1; c <= 8; c++) begin
         step();
         chk("start_phase",  8'(phase),  8'(ph_tab[c-1]));
         chk("start_stb",    8'(stb),    8'(stb_tab[c-1]));
         chk("start_valid",  8'(ov),     8'(ov_tab[c-1]));
         chk("start_phase4", 8'(phase2), 8'(ph4_tab[c-1]));
         chk("start_valid4", 8'(ov2),    8'(ov4_tab[c-1]));
         if (c == 1) chk("start_busy", 8'(busy), 8'd1);
      end
      en2 = 0;

      // cycle 8: RUN, phase 1 -> bank request, held one cycle past the ack
      req = 1; nxt = 1; step();
      chk("bank_noack_early", 8'(ack), 8'd0);
      step();
      chk("bank_ack1",  8'(ack), 8'd1);
      chk("bank_act1",  8'(act), 8'd1);
      chk("bank_stb1",  8'(stb), 8'd1);
      step();
      chk("bank_ack_width", 8'(ack), 8'd0);
      req = 0; step(); step();
      chk("bank_ack2",  8'(ack), 8'd1);
      chk("bank_stb2",  8'(stb), 8'd1);
      step();

      // cycle 14: phase 1, drop enable -> DRAIN then IDLE
      chk("drain_pre_phase", 8'(phase), 8'd1);
      en = 0; step();
      chk("drain_phase", 8'(phase), 8'd0);
      chk("drain_valid", 8'(ov),    8'd1);
      step();
      chk("drain_idle_phase", 8'(phase), 8'd2);
      chk("drain_idle_valid", 8'(ov),    8'd0);
      chk("drain_idle_stb",   8'(stb),   8'd0);
      chk("drain_idle_busy",  8'(busy),  8'd0);

      // restart, drop enable on a RUN phase-0 cycle
      en = 1; repeat (9) step();
      chk("run0_phase", 8'(phase), 8'd0);
      chk("run0_valid", 8'(ov),    8'd1);
      en = 0; step();
      chk("run0_idle_busy",  8'(busy),  8'd0);
      chk("run0_idle_valid", 8'(ov),    8'd0);
      chk("run0_idle_stb",   8'(stb),   8'd0);
      chk("run0_idle_phase", 8'(phase), 8'd2);

      // abort during WARM at its first phase-0 cycle
      en = 1; repeat (3) step();
      chk("warm_abort_phase", 8'(phase), 8'd0);
      chk("warm_abort_busy",  8'(busy),  8'd1);
      en = 0; step();
      chk("warm_abort_idle",  8'(busy),  8'd0);
      chk("warm_abort_valid", 8'(ov),    8'd0);

      // IDLE commit, then request coincident with start
      req = 1; nxt = 0; step();
      chk("idle_ack",  8'(ack), 8'd1);
      chk("idle_bank", 8'(act), 8'd0);
      req = 0; step();
      chk("idle_ack_width", 8'(ack), 8'd0);
      req = 1; nxt = 1; en = 1; step();
      chk("start_bank_stb", 8'(stb), 8'd1);
      chk("start_bank_ack", 8'(ack), 8'd1);
      chk("start_bank_act", 8'(act), 8'd1);
      req = 0; step();
      chk("start_bank_single", 8'(ack), 8'd0);

      // reset mid-RUN at phase 1 with a request pending
      repeat (6) step();
      chk("pre_rst_phase", 8'(phase), 8'd1);
      chk("pre_rst_valid", 8'(ov),    8'd1);
      req = 1; nxt = 0; reset = 0; step();
      chk("midrst_phase", 8'(phase), 8'd2);
      chk("midrst_busy",  8'(busy),  8'd0);
      chk("midrst_valid", 8'(ov),    8'd0);
      chk("midrst_stb",   8'(stb),   8'd0);
      chk("midrst_ack",   8'(ack),   8'd0);
      chk("midrst_bank",  8'(act),   8'd0);
      reset = 1; req = 0; en = 0; repeat (3) step();
      chk("post_rst_ack",  8'(ack), 8'd0);
      chk("post_rst_bank", 8'(act), 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
